// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache between a CPU request port and a word RAM.
// Optional hit/miss statistics ports are compiled in when CACHE_STATS_EN is defined.
module cache_controller #(
  parameter int unsigned LINES       = 16,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_write,
  input  logic [31:0] mem_out
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = 32 - IdxW;
  localparam logic [3:0] CntLast = 4'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMemRead,
    StMemWrite,
    StResp
  } state_e;

  state_e            state_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic              write_q;
  logic              phase_q;
  logic [3:0]        cnt_q;
  logic              lk_valid_q;
  logic [TagW-1:0]   lk_tag_q;
  logic [31:0]       lk_data_q;
  logic [LINES-1:0]  line_valid_q;
  logic [TagW-1:0]   line_tag  [LINES];
  logic [31:0]       line_data [LINES];

  logic [IdxW-1:0]   idx;
  logic [TagW-1:0]   tag;
  logic              hit;
  logic              fill_en;
  logic              upd_en;

  always_comb begin
    idx     = addr_q[IdxW-1:0];
    tag     = addr_q[31:IdxW];
    hit     = lk_valid_q && (lk_tag_q == tag);
    fill_en = (state_q == StMemRead) && (cnt_q == CntLast);
    upd_en  = (state_q == StMemWrite) && (cnt_q == CntLast) && hit;
  end

  // Line storage needs no reset: the valid bits alone gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_tag[idx]  <= tag;
      line_data[idx] <= mem_out;
    end else if (upd_en) begin
      line_data[idx] <= data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      write_q      <= 1'b0;
      phase_q      <= 1'b0;
      cnt_q        <= '0;
      lk_valid_q   <= 1'b0;
      lk_tag_q     <= '0;
      lk_data_q    <= '0;
      line_valid_q <= '0;
      ready        <= 1'b1;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      mem_address  <= '0;
      mem_data     <= '0;
      mem_write    <= 1'b0;
`ifdef CACHE_STATS_EN
      hit_count    <= '0;
      miss_count   <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= req_address;
            data_q  <= req_data;
            write_q <= req_write;
            phase_q <= 1'b0;
            ready   <= 1'b0;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          // First cycle registers the line read, second cycle compares and dispatches.
          if (!phase_q) begin
            phase_q    <= 1'b1;
            lk_valid_q <= line_valid_q[idx];
            lk_tag_q   <= line_tag[idx];
            lk_data_q  <= line_data[idx];
          end else begin
            cnt_q <= '0;
            if (write_q) begin
              mem_address <= addr_q;
              mem_data    <= data_q;
              mem_write   <= 1'b1;
              state_q     <= StMemWrite;
            end else if (hit) begin
              resp_data  <= lk_data_q;
              resp_valid <= 1'b1;
              state_q    <= StResp;
`ifdef CACHE_STATS_EN
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
`endif
            end else begin
              mem_address <= addr_q;
              state_q     <= StMemRead;
`ifdef CACHE_STATS_EN
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
`endif
            end
          end
        end
        StMemRead: begin
          if (cnt_q == CntLast) begin
            resp_data         <= mem_out;
            resp_valid        <= 1'b1;
            line_valid_q[idx] <= 1'b1;
            state_q           <= StResp;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StMemWrite: begin
          if (cnt_q == CntLast) begin
            mem_write  <= 1'b0;
            resp_data  <= data_q;
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StResp: begin
          ready   <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural word RAM whose read latency tracks ML.
module tb_cache_controller;

`ifdef CACHE_STATS_EN
  localparam int ML = 3;
`else
  localparam int ML = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_data = '0;
  logic        ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_write;
  logic [31:0] mem_out;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_controller #(
    .LINES(16),
    .MEM_LATENCY(ML)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_write(req_write),
    .req_address(req_address),
    .req_data(req_data),
    .ready(ready),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .mem_write(mem_write),
    .mem_out(mem_out)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  // RAM model: data read ML edges after the address is driven is valid at that edge.
  logic [31:0] ram_mem [4096];
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram_mem[pre_addr] <= pre_data;
    else if (mem_write) ram_mem[mem_address[11:0]] <= mem_data;
  end

  generate
    if (ML == 1) begin : g_comb
      assign mem_out = ram_mem[mem_address[11:0]];
    end else begin : g_pipe
      logic [11:0] ap [ML-1];
      always @(posedge clk) begin
        ap[0] <= mem_address[11:0];
        for (int i = 1; i < ML - 1; i++) ap[i] <= ap[i-1];
      end
      assign mem_out = ram_mem[ap[ML-2]];
    end
  endgenerate

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One request; returns latency in edges after acceptance, read data, mem_write cycles, last mem_address.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output int wcyc,
                        output logic [31:0] maddr);
    int waits = 0;
    @(negedge clk);
    while (!ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL req_ready: ready=%b want 1", ready);
    end
    req = 1'b1; req_write = w; req_address = a; req_data = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    lat = -1; rd = 'x; wcyc = 0; maddr = 'x;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_write) begin
        wcyc++;
        maddr = mem_address;
      end
      if (resp_valid) begin
        lat = k;
        rd  = resp_data;
      end
    end
    if (!w) maddr = mem_address;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({ready, resp_valid, mem_write} !== 3'b100) begin
      fails++;
      $display("FAIL reset_ctrl: ready/resp_valid/mem_write=%b want 100",
               {ready, resp_valid, mem_write});
    end
    tests++;
    if (resp_data !== 32'd0 || mem_address !== 32'd0 || mem_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_data: resp_data=%0d mem_address=%0d mem_data=%0d want 0 0 0",
               resp_data, mem_address, mem_data);
    end
`ifdef CACHE_STATS_EN
    tests++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_stats: hit=%0d miss=%0d want 0 0", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_read_miss_hit();
    int lat, wc;
    logic [31:0] rd, ma;
    preload(12'd0, 32'd14528);
    do_req(1'b0, 32'd0, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || rd !== 32'd14528 || wc !== 0) begin
      fails++;
      $display("FAIL read0_miss: lat=%0d data=%0d wcyc=%0d want %0d 14528 0", lat, rd, wc, 2 + ML);
    end
    do_req(1'b0, 32'd0, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 || rd !== 32'd14528 || wc !== 0) begin
      fails++;
      $display("FAIL read0_hit: lat=%0d data=%0d wcyc=%0d want 2 14528 0", lat, rd, wc);
    end
  endtask

  task automatic test_write_no_allocate();
    int lat, wc;
    logic [31:0] rd, ma;
    do_req(1'b1, 32'd2001, 32'd25369366, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || wc !== ML || ma !== 32'd2001 || rd !== 32'd25369366) begin
      fails++;
      $display("FAIL write2001: lat=%0d wcyc=%0d addr=%0d echo=%0d want %0d %0d 2001 25369366",
               lat, wc, ma, rd, 2 + ML, ML);
    end
    do_req(1'b0, 32'd2001, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || rd !== 32'd25369366 || ma !== 32'd2001) begin
      fails++;
      $display("FAIL read2001_miss: lat=%0d data=%0d addr=%0d want %0d 25369366 2001",
               lat, rd, ma, 2 + ML);
    end
  endtask

  task automatic test_alias();
    int lat, wc;
    logic [31:0] rd, ma;
    do_req(1'b1, 32'd2816867292, 32'd526421, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || wc !== ML || ma !== 32'd2816867292) begin
      fails++;
      $display("FAIL alias_write: lat=%0d wcyc=%0d addr=%0d want %0d %0d 2816867292",
               lat, wc, ma, 2 + ML, ML);
    end
    do_req(1'b0, 32'd3036, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || rd !== 32'd526421 || ma !== 32'd3036) begin
      fails++;
      $display("FAIL alias_read3036: lat=%0d data=%0d addr=%0d want %0d 526421 3036",
               lat, rd, ma, 2 + ML);
    end
    do_req(1'b0, 32'd2816867292, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || rd !== 32'd526421) begin
      fails++;
      $display("FAIL alias_evicted: lat=%0d data=%0d want %0d 526421", lat, rd, 2 + ML);
    end
  endtask

  task automatic test_write_hit();
    int lat, wc;
    logic [31:0] rd, ma;
    do_req(1'b0, 32'd3036, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || rd !== 32'd526421) begin
      fails++;
      $display("FAIL whit_fill: lat=%0d data=%0d want %0d 526421", lat, rd, 2 + ML);
    end
    do_req(1'b1, 32'd3036, 32'd14528, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || wc !== ML || ma !== 32'd3036) begin
      fails++;
      $display("FAIL whit_write: lat=%0d wcyc=%0d addr=%0d want %0d %0d 3036",
               lat, wc, ma, 2 + ML, ML);
    end
    do_req(1'b0, 32'd3036, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 || rd !== 32'd14528 || wc !== 0) begin
      fails++;
      $display("FAIL whit_reread: lat=%0d data=%0d wcyc=%0d want 2 14528 0", lat, rd, wc);
    end
    do_req(1'b0, 32'd2816867292, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || rd !== 32'd14528) begin
      fails++;
      $display("FAIL whit_alias: lat=%0d data=%0d want %0d 14528", lat, rd, 2 + ML);
    end
  endtask

  task automatic test_back_to_back();
    int lat, wc, resp_seen, busy_wc, k;
    logic [31:0] rd, ma;
    preload(12'd100, 32'd55);
    resp_seen = 0; busy_wc = 0; k = 0;
    @(negedge clk);
    req = 1'b1; req_write = 1'b0; req_address = 32'd0; req_data = 32'd0;
    @(posedge clk);
    @(negedge clk);
    // Held write while busy must be ignored.
    req_write = 1'b1; req_address = 32'd100; req_data = 32'd999;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
      if (mem_write) busy_wc++;
      if (resp_valid) resp_seen++;
    end
    req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_write) busy_wc++;
      if (resp_valid) resp_seen++;
    end
    tests++;
    if (resp_seen !== 1 || busy_wc !== 0) begin
      fails++;
      $display("FAIL busy_ignored: resps=%0d wcyc=%0d want 1 0", resp_seen, busy_wc);
    end
    do_req(1'b0, 32'd100, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || rd !== 32'd55) begin
      fails++;
      $display("FAIL busy_read100: lat=%0d data=%0d want %0d 55", lat, rd, 2 + ML);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat, wc, resp_seen;
    logic [31:0] rd, ma;
    resp_seen = 0;
    do_req(1'b0, 32'd0, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL rmid_prehit: lat=%0d want 2", lat);
    end
    @(negedge clk);
    req = 1'b1; req_write = 1'b1; req_address = 32'd5; req_data = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (mem_write !== 1'b1 || mem_address !== 32'd5) begin
      fails++;
      $display("FAIL rmid_inwrite: mem_write=%b addr=%0d want 1 5", mem_write, mem_address);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (mem_write !== 1'b0 || ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rmid_async: mem_write=%b ready=%b resp_valid=%b want 0 1 0",
               mem_write, ready, resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    tests++;
    if (resp_seen !== 0) begin
      fails++;
      $display("FAIL rmid_noresp: resps=%0d want 0", resp_seen);
    end
    do_req(1'b0, 32'd0, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || rd !== 32'd14528) begin
      fails++;
      $display("FAIL rmid_invalid: lat=%0d data=%0d want %0d 14528", lat, rd, 2 + ML);
    end
  endtask

  task automatic test_stats();
    int lat, wc;
    logic [31:0] rd, ma;
    apply_reset();
    preload(12'd16, 32'd77);
    preload(12'd32, 32'd88);
    do_req(1'b0, 32'd16, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || rd !== 32'd77) begin
      fails++;
      $display("FAIL stats_miss16: lat=%0d data=%0d want %0d 77", lat, rd, 2 + ML);
    end
    do_req(1'b0, 32'd32, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 + ML || rd !== 32'd88) begin
      fails++;
      $display("FAIL stats_miss32: lat=%0d data=%0d want %0d 88", lat, rd, 2 + ML);
    end
    do_req(1'b0, 32'd32, 32'd0, lat, rd, wc, ma);
    tests++;
    if (lat !== 2 || rd !== 32'd88) begin
      fails++;
      $display("FAIL stats_hit32: lat=%0d data=%0d want 2 88", lat, rd);
    end
    do_req(1'b1, 32'd48, 32'd1, lat, rd, wc, ma);
`ifdef CACHE_STATS_EN
    tests++;
    if (miss_count !== 16'd2 || hit_count !== 16'd1) begin
      fails++;
      $display("FAIL stats_counts: miss=%0d hit=%0d want 2 1", miss_count, hit_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_no_allocate();
    test_alias();
    test_write_hit();
    test_back_to_back();
    test_reset_mid_write();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
